// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared types and constants for the decode/issue stage of the ARM-subset
// core: FSM states, main-decoder ALU operation classes, multi-cycle op
// classes, decoder field widths, MUL/DIV match patterns and the registered
// control bundle layout.
// ---------------------------------------------------------------------------
package decode_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MC_WAIT = 2'd1,
      S_MC_WB   = 2'd2
   } state_e;

   // Main-decoder ALU request: fixed add, fixed subtract, or decode from Funct.
   typedef enum logic [1:0] {
      ALU_POS = 2'b00,
      ALU_NEG = 2'b01,
      ALU_DP  = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      MC_NONE = 2'b00,
      MC_MUL  = 2'b01,
      MC_DIV  = 2'b10
   } mc_op_e;

   // Main decode word: {Branch, MemtoReg, MemW, ALUSrc, ImmSrc[1:0], RegW,
   //                    RegSrc[2:0], ALUOp[1:0], MCOp[1:0]}
   localparam int unsigned MAIN_DEC_W = 14;
   // ALU decode input: Funct[4:0] = {cmd[3:0], S}
   localparam int unsigned ALU_DEC_W  = 5;

   // MUL: Instr[27:21] == 0, Instr[7:4] == 1001
   localparam logic [6:0] MUL_HI = 7'h00;
   localparam logic [3:0] MUL_LO = 4'b1001;
   // DIV: Instr[27:20] == 0x7F, Instr[7:4] == 1111
   localparam logic [7:0] DIV_HI = 8'h7F;
   localparam logic [3:0] DIV_LO = 4'b1111;

   typedef struct packed {
      logic       pcs;
      logic       regw;
      logic       memw;
      logic       memtoreg;
      logic       alusrc;
      logic       nowrite;
      logic [1:0] immsrc;
      logic [2:0] regsrc;
      logic [1:0] alucontrol;
      logic [1:0] flagw;
   } ctrl_t;

endpackage

// File: rtl/decode_core.sv
// ---------------------------------------------------------------------------
// decode_core
// Purely combinational instruction decoder: maps a 32-bit instruction to the
// control bundle plus a multi-cycle op class. Unsupported encodings produce
// an all-zero bundle (NOP). With MC_EN=0, MUL/DIV encodings are NOPs.
// Ports:
//   instr_i   in  32  instruction to decode
//   ctrl_o    out     decoded control bundle
//   mc_op_o   out  2  MC_NONE / MC_MUL / MC_DIV
// ---------------------------------------------------------------------------
module decode_core
   import decode_pkg::*;
#(
   parameter bit MC_EN = 1'b1
) (
   input  logic [31:0] instr_i,
   output ctrl_t       ctrl_o,
   output mc_op_e      mc_op_o
);

   logic [MAIN_DEC_W-1:0] main_dec;
   logic [ALU_DEC_W-1:0]  alu_field;
   logic                  main_nop;
   logic                  dp_nop;
   logic                  is_mul;
   logic                  is_div;
   alu_op_e               mem_op;

   logic       branch;
   logic       memtoreg;
   logic       memw;
   logic       alusrc;
   logic [1:0] immsrc;
   logic       regw;
   logic [2:0] regsrc;
   logic [1:0] alu_op_bits;
   logic [1:0] mc_op_bits;
   alu_op_e    alu_op;

   logic [1:0] alu_ctl;
   logic [1:0] flagw;
   logic       nowrite;

   // Condition, Rn, Rs/rotate and Rm fields do not affect control decode.
   logic unused_bits;
   assign unused_bits = ^{instr_i[31:28], instr_i[19:16], instr_i[11:8], instr_i[3:0]};

   assign alu_field = instr_i[24:20];
   assign is_mul    = (instr_i[27:21] == MUL_HI) && (instr_i[7:4] == MUL_LO);
   assign is_div    = (instr_i[27:20] == DIV_HI) && (instr_i[7:4] == DIV_LO);
   assign mem_op    = instr_i[23] ? ALU_POS : ALU_NEG;

   always_comb begin
      main_dec = '0;
      main_nop = 1'b0;
      // MUL/DIV overlap the DP and LDR/STR spaces, so they are matched first.
      if (is_mul || is_div) begin
         if (MC_EN) begin
            main_dec = {4'b0000, 2'b00, 1'b0, 3'b000, ALU_POS,
                        (is_div ? MC_DIV : MC_MUL)};
         end else begin
            main_nop = 1'b1;
         end
      end else begin
         case (instr_i[27:26])
            2'b00: main_dec = {1'b0, 1'b0, 1'b0, instr_i[25], 2'b00, 1'b1,
                               3'b000, ALU_DP, MC_NONE};
            2'b01: begin
               if (instr_i[25]) begin
                  main_nop = 1'b1;
               end else if (instr_i[20]) begin
                  main_dec = {1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1,
                              3'b000, mem_op, MC_NONE};
               end else begin
                  main_dec = {1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0,
                              3'b010, mem_op, MC_NONE};
               end
            end
            2'b10: main_dec = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0,
                               3'b001, ALU_POS, MC_NONE};
            default: main_nop = 1'b1;
         endcase
      end
   end

   assign {branch, memtoreg, memw, alusrc, immsrc, regw, regsrc,
           alu_op_bits, mc_op_bits} = main_dec;
   assign alu_op = alu_op_e'(alu_op_bits);

   always_comb begin
      alu_ctl = 2'b00;
      flagw   = 2'b00;
      nowrite = 1'b0;
      dp_nop  = 1'b0;
      case (alu_op)
         ALU_POS: alu_ctl = 2'b00;
         ALU_NEG: alu_ctl = 2'b01;
         ALU_DP: begin
            case (alu_field[4:1])
               4'b0100: begin alu_ctl = 2'b00; flagw = {2{alu_field[0]}}; end
               4'b0010: begin alu_ctl = 2'b01; flagw = {2{alu_field[0]}}; end
               4'b0000: begin alu_ctl = 2'b10; flagw = {alu_field[0], 1'b0}; end
               4'b1100: begin alu_ctl = 2'b11; flagw = {alu_field[0], 1'b0}; end
               // CMP/CMN only exist with S=1; otherwise the encoding is unused.
               4'b1010: begin
                  alu_ctl = 2'b01; flagw = 2'b11; nowrite = 1'b1;
                  dp_nop  = ~alu_field[0];
               end
               4'b1011: begin
                  alu_ctl = 2'b00; flagw = 2'b11; nowrite = 1'b1;
                  dp_nop  = ~alu_field[0];
               end
               default: dp_nop = 1'b1;
            endcase
         end
         default: alu_ctl = 2'b00;
      endcase
   end

   always_comb begin
      ctrl_o  = '0;
      mc_op_o = MC_NONE;
      if (!(main_nop || dp_nop)) begin
         ctrl_o.pcs        = branch | (regw & (instr_i[15:12] == 4'hF));
         ctrl_o.regw       = regw;
         ctrl_o.memw       = memw;
         ctrl_o.memtoreg   = memtoreg;
         ctrl_o.alusrc     = alusrc;
         ctrl_o.nowrite    = nowrite;
         ctrl_o.immsrc     = immsrc;
         ctrl_o.regsrc     = regsrc;
         ctrl_o.alucontrol = alu_ctl;
         ctrl_o.flagw      = flagw;
         mc_op_o           = mc_op_e'(mc_op_bits);
      end
   end

endmodule

// File: rtl/decode_issue_stage.sv
// ---------------------------------------------------------------------------
// decode_issue_stage
// Registered decode stage: accepts one instruction per cycle (valid/ready),
// holds the decoded bundle in the Decode->Execute register with backpressure
// and flush, and sequences MUL/DIV through the MCycle unit with a watchdog.
// Ports:
//   CLK, RESET              clock (rising edge), async active-high reset
//   Instr, InstrValid       instruction input and its valid
//   InstrReady              stage accepts Instr this cycle (combinational)
//   ExReady                 Execute consumes the current output
//   Flush                   kill held instruction / abandon multi-cycle op
//   MC_Done                 MCycle result ready pulse
//   DValid + control        registered bundle (PCS..FlagW)
//   M_Start, MCycleOp, M_W  MCycle start pulse, op (0 MUL/1 DIV), WB select
//   McTimeout               sticky watchdog-expired flag
// ---------------------------------------------------------------------------
module decode_issue_stage
   import decode_pkg::*;
#(
   parameter bit          MC_EN      = 1'b1,
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned CNT_W      = $clog2(MC_TIMEOUT + 1)
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr,
   input  logic        InstrValid,
   output logic        InstrReady,
   input  logic        ExReady,
   input  logic        Flush,
   input  logic        MC_Done,
   output logic        DValid,
   output logic        PCS,
   output logic        RegW,
   output logic        MemW,
   output logic        MemtoReg,
   output logic        ALUSrc,
   output logic        NoWrite,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  RegSrc,
   output logic [1:0]  ALUControl,
   output logic [1:0]  FlagW,
   output logic        M_Start,
   output logic        MCycleOp,
   output logic        M_W,
   output logic        McTimeout
);

   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MC_TIMEOUT);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] wd_q,      wd_d;
   ctrl_t            ctrl_q,    ctrl_d;
   logic             dvalid_q,  dvalid_d;
   logic             mstart_q,  mstart_d;
   logic             mcop_q,    mcop_d;
   logic             mw_q,      mw_d;
   logic             timeout_q, timeout_d;

   ctrl_t            dec_ctrl;
   mc_op_e           dec_mc_op;
   logic             accept;
   logic [CNT_W-1:0] wd_inc;

   decode_core #(
      .MC_EN (MC_EN)
   ) u_decode_core (
      .instr_i (Instr),
      .ctrl_o  (dec_ctrl),
      .mc_op_o (dec_mc_op)
   );

   assign InstrReady = (state_q == S_IDLE) & ~Flush & (~dvalid_q | ExReady);
   assign accept     = InstrValid & InstrReady;
   assign wd_inc     = wd_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      ctrl_d    = ctrl_q;
      dvalid_d  = dvalid_q;
      mstart_d  = 1'b0;
      mcop_d    = mcop_q;
      mw_d      = mw_q;
      timeout_d = timeout_q;
      if (Flush) begin
         state_d  = S_IDLE;
         wd_d     = '0;
         dvalid_d = 1'b0;
         mw_d     = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  ctrl_d = dec_ctrl;
                  mw_d   = 1'b0;
                  if (dec_mc_op != MC_NONE) begin
                     state_d  = S_MC_WAIT;
                     dvalid_d = 1'b0;
                     mstart_d = 1'b1;
                     mcop_d   = (dec_mc_op == MC_DIV);
                     wd_d     = '0;
                  end else begin
                     dvalid_d = 1'b1;
                  end
               end else if (ExReady) begin
                  dvalid_d = 1'b0;
               end
            end
            S_MC_WAIT: begin
               if (MC_Done) begin
                  state_d       = S_MC_WB;
                  dvalid_d      = 1'b1;
                  ctrl_d.regw   = 1'b1;
                  ctrl_d.regsrc = 3'b100;
                  mw_d          = 1'b1;
               end else if (wd_inc == WD_LIMIT) begin
                  state_d   = S_IDLE;
                  dvalid_d  = 1'b0;
                  timeout_d = 1'b1;
                  wd_d      = wd_inc;
               end else begin
                  wd_d = wd_inc;
               end
            end
            S_MC_WB: begin
               if (ExReady) begin
                  state_d  = S_IDLE;
                  dvalid_d = 1'b0;
                  mw_d     = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         wd_q      <= '0;
         ctrl_q    <= '0;
         dvalid_q  <= 1'b0;
         mstart_q  <= 1'b0;
         mcop_q    <= 1'b0;
         mw_q      <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         ctrl_q    <= ctrl_d;
         dvalid_q  <= dvalid_d;
         mstart_q  <= mstart_d;
         mcop_q    <= mcop_d;
         mw_q      <= mw_d;
         timeout_q <= timeout_d;
      end
   end

   assign DValid     = dvalid_q;
   assign PCS        = ctrl_q.pcs;
   assign RegW       = ctrl_q.regw;
   assign MemW       = ctrl_q.memw;
   assign MemtoReg   = ctrl_q.memtoreg;
   assign ALUSrc     = ctrl_q.alusrc;
   assign NoWrite    = ctrl_q.nowrite;
   assign ImmSrc     = ctrl_q.immsrc;
   assign RegSrc     = ctrl_q.regsrc;
   assign ALUControl = ctrl_q.alucontrol;
   assign FlagW      = ctrl_q.flagw;
   assign M_Start    = mstart_q;
   assign MCycleOp   = mcop_q;
   assign M_W        = mw_q;
   assign McTimeout  = timeout_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_issue_stage
// Self-checking bench for decode_issue_stage: directed handshake / MCycle /
// flush / timeout / backpressure steps followed by randomized non-MC traffic
// compared against a field-level reference decoder and transaction model.
// Two instances: MC_EN=1 with MC_TIMEOUT=8, and MC_EN=0.
// ---------------------------------------------------------------------------
module tb_decode_issue_stage;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] Instr;
   logic        InstrValid, ExReady, Flush, MC_Done;

   logic        InstrReady, DValid, PCS, RegW, MemW, MemtoReg, ALUSrc, NoWrite;
   logic [1:0]  ImmSrc, ALUControl, FlagW;
   logic [2:0]  RegSrc;
   logic        M_Start, MCycleOp, M_W, McTimeout;

   logic        n_InstrReady, n_DValid, n_PCS, n_RegW, n_MemW, n_MemtoReg, n_ALUSrc, n_NoWrite;
   logic [1:0]  n_ImmSrc, n_ALUControl, n_FlagW;
   logic [2:0]  n_RegSrc;
   logic        n_M_Start, n_MCycleOp, n_M_W, n_McTimeout;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 CLK = ~CLK;

   decode_issue_stage #(.MC_EN(1'b1), .MC_TIMEOUT(8)) u_dut (
      .CLK(CLK), .RESET(RESET), .Instr(Instr), .InstrValid(InstrValid),
      .InstrReady(InstrReady), .ExReady(ExReady), .Flush(Flush), .MC_Done(MC_Done),
      .DValid(DValid), .PCS(PCS), .RegW(RegW), .MemW(MemW), .MemtoReg(MemtoReg),
      .ALUSrc(ALUSrc), .NoWrite(NoWrite), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
      .ALUControl(ALUControl), .FlagW(FlagW), .M_Start(M_Start), .MCycleOp(MCycleOp),
      .M_W(M_W), .McTimeout(McTimeout));

   decode_issue_stage #(.MC_EN(1'b0), .MC_TIMEOUT(8)) u_dut_nomc (
      .CLK(CLK), .RESET(RESET), .Instr(Instr), .InstrValid(InstrValid),
      .InstrReady(n_InstrReady), .ExReady(ExReady), .Flush(Flush), .MC_Done(MC_Done),
      .DValid(n_DValid), .PCS(n_PCS), .RegW(n_RegW), .MemW(n_MemW), .MemtoReg(n_MemtoReg),
      .ALUSrc(n_ALUSrc), .NoWrite(n_NoWrite), .ImmSrc(n_ImmSrc), .RegSrc(n_RegSrc),
      .ALUControl(n_ALUControl), .FlagW(n_FlagW), .M_Start(n_M_Start), .MCycleOp(n_MCycleOp),
      .M_W(n_M_W), .McTimeout(n_McTimeout));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Bundle packing used throughout the bench:
   // {PCS,RegW,MemW,MemtoReg,ALUSrc,NoWrite,ImmSrc,RegSrc,ALUControl,FlagW}
   function automatic logic [15:0] dut_bundle();
      return {PCS, RegW, MemW, MemtoReg, ALUSrc, NoWrite, ImmSrc, RegSrc, ALUControl, FlagW};
   endfunction

   function automatic logic [15:0] nomc_bundle();
      return {n_PCS, n_RegW, n_MemW, n_MemtoReg, n_ALUSrc, n_NoWrite, n_ImmSrc, n_RegSrc,
              n_ALUControl, n_FlagW};
   endfunction

   function automatic logic is_mc(input logic [31:0] ins);
      return ((ins[27:21] == 7'h00) && (ins[7:4] == 4'b1001)) ||
             ((ins[27:20] == 8'h7F) && (ins[7:4] == 4'b1111));
   endfunction

   // Reference decoder for non-MC instructions, written from the instruction
   // classes: data processing, single data transfer, branch, everything else NOP.
   function automatic logic [15:0] ref_decode(input logic [31:0] ins);
      logic       pcs, regw, memw, m2r, alusrc, nw, branch, arith, ok;
      logic [1:0] imm, ctl, fw;
      logic [2:0] rs;
      {pcs, regw, memw, m2r, alusrc, nw, branch, arith, ok} = '0;
      imm = 2'b00; ctl = 2'b00; fw = 2'b00; rs = 3'b000;
      if (!is_mc(ins)) begin
         if (ins[27:26] == 2'b00) begin
            case (ins[24:21])
               4'd4:  begin ok = 1; arith = 1; ctl = 2'd0; end            // ADD
               4'd2:  begin ok = 1; arith = 1; ctl = 2'd1; end            // SUB
               4'd0:  begin ok = 1; ctl = 2'd2; end                       // AND
               4'd12: begin ok = 1; ctl = 2'd3; end                       // ORR
               4'd10: begin ok = ins[20]; arith = 1; ctl = 2'd1; nw = 1; end // CMP
               4'd11: begin ok = ins[20]; arith = 1; ctl = 2'd0; nw = 1; end // CMN
               default: ok = 0;
            endcase
            if (ok) begin
               regw   = 1;
               alusrc = ins[25];
               fw     = ins[20] ? (arith ? 2'b11 : 2'b10) : 2'b00;
            end else begin
               ctl = 2'b00; nw = 0;
            end
         end else if (ins[27:26] == 2'b01 && !ins[25]) begin
            alusrc = 1; imm = 2'b01;
            ctl    = ins[23] ? 2'd0 : 2'd1;
            if (ins[20]) begin m2r = 1; regw = 1; end
            else begin memw = 1; rs = 3'b010; end
         end else if (ins[27:26] == 2'b10) begin
            branch = 1; alusrc = 1; imm = 2'b10; rs = 3'b001;
         end
      end
      pcs = branch | (regw & (ins[15:12] == 4'd15));
      return {pcs, regw, memw, m2r, alusrc, nw, imm, rs, ctl, fw};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] x;
      logic [3:0]  cmds [8] = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10, 4'd11, 4'd1, 4'd13};
      x = $urandom;
      x[31:28] = 4'hE;
      case ($urandom_range(0, 4))
         0, 1: begin
            x[27:26] = 2'b00;
            x[24:21] = cmds[$urandom_range(0, 7)];
            x[4]     = 1'b0;
         end
         2: begin
            x[27:26] = 2'b01;
            x[25]    = ($urandom_range(0, 3) == 0);
         end
         3: x[27:26] = 2'b10;
         default: x[27:26] = 2'b11;
      endcase
      if (is_mc(x)) x[7:4] = 4'b0000;
      return x;
   endfunction

   initial begin
      #100000;
      $display("FAIL sim_watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_b, ld_b;
      logic        exp_v, exp_rdy, iv, er, fl;

      RESET = 1'b1; Instr = '0; InstrValid = 0; ExReady = 0; Flush = 0; MC_Done = 0;
      #12;
      chk("reset_outputs", {DValid, dut_bundle(), M_Start, MCycleOp, M_W, McTimeout}, 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      #1;
      chk("reset_ready", InstrReady, 1);

      // ADD r1,r2,r3
      Instr = 32'hE0821003; InstrValid = 1; ExReady = 1;
      tick();
      InstrValid = 0;
      chk("add_dvalid", DValid, 1);
      chk("add_regw", RegW, 1);
      chk("add_alusrc", ALUSrc, 0);
      chk("add_aluctl", ALUControl, 2'b00);
      chk("add_flagw", FlagW, 2'b00);
      chk("add_nowrite", NoWrite, 0);
      chk("add_bundle", dut_bundle(), ref_decode(32'hE0821003));
      tick();
      chk("add_consumed", DValid, 0);

      // CMP r1,#5 then B back-to-back
      Instr = 32'hE3510005; InstrValid = 1;
      tick();
      chk("cmp_aluctl", ALUControl, 2'b01);
      chk("cmp_flagw", FlagW, 2'b11);
      chk("cmp_nowrite", NoWrite, 1);
      chk("cmp_alusrc", ALUSrc, 1);
      Instr = 32'hEA000002;
      #1 chk("cmp_b_ready", InstrReady, 1);
      tick();
      InstrValid = 0;
      chk("b_dvalid", DValid, 1);
      chk("b_pcs", PCS, 1);
      chk("b_immsrc", ImmSrc, 2'b10);
      chk("b_regw", RegW, 0);
      tick();

      // MUL r0,r1,r2 with MC_Done after 5 cycles
      Instr = 32'hE0000291; InstrValid = 1;
      tick();
      InstrValid = 0;
      chk("mul_mstart", M_Start, 1);
      chk("mul_op", MCycleOp, 0);
      chk("mul_dvalid0", DValid, 0);
      chk("mul_ready0", InstrReady, 0);
      tick();
      chk("mul_mstart_pulse", M_Start, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mul_wait_dvalid", DValid, 0);
      end
      MC_Done = 1;
      ExReady = 0;
      tick();
      MC_Done = 0;
      chk("mul_wb_dvalid", DValid, 1);
      chk("mul_wb_mw", M_W, 1);
      chk("mul_wb_regw", RegW, 1);
      chk("mul_wb_regsrc", RegSrc, 3'b100);
      chk("mul_wb_ready_hold", InstrReady, 0);
      tick();
      chk("mul_wb_held", {DValid, M_W, RegW, RegSrc}, {1'b1, 1'b1, 1'b1, 3'b100});
      ExReady = 1;
      tick();
      chk("mul_wb_done_dvalid", DValid, 0);
      chk("mul_wb_done_ready", InstrReady, 1);
      chk("mul_no_timeout", McTimeout, 0);

      // MUL abandoned by Flush; late MC_Done ignored
      Instr = 32'hE0000291; InstrValid = 1;
      tick();
      InstrValid = 0;
      chk("fl_mstart", M_Start, 1);
      tick(); tick();
      Flush = 1; Instr = 32'hE0821003; InstrValid = 1;
      #1 chk("fl_ready_blocked", InstrReady, 0);
      tick();
      Flush = 0;
      chk("fl_dvalid", DValid, 0);
      chk("fl_mstart0", M_Start, 0);
      #1 chk("fl_ready_after", InstrReady, 1);
      tick();
      InstrValid = 0;
      chk("fl_next_dvalid", DValid, 1);
      chk("fl_next_bundle", dut_bundle(), ref_decode(32'hE0821003));
      chk("fl_next_mw", M_W, 0);
      MC_Done = 1;
      tick();
      MC_Done = 0;
      chk("fl_late_done_dvalid", DValid, 0);
      chk("fl_late_done_mw", M_W, 0);

      // Backpressure: LDR held for 3 cycles while STR waits
      Instr = 32'hE5912004; InstrValid = 1;
      tick();
      ld_b = dut_bundle();
      chk("ldr_bundle", ld_b, ref_decode(32'hE5912004));
      Instr = 32'hE5012008; ExReady = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_ready", InstrReady, 0);
         tick();
         chk("bp_dvalid", DValid, 1);
         chk("bp_bundle", dut_bundle(), ref_decode(32'hE5912004));
      end
      ExReady = 1;
      #1 chk("bp_release_ready", InstrReady, 1);
      tick();
      InstrValid = 0;
      chk("str_bundle", dut_bundle(), ref_decode(32'hE5012008));
      chk("str_dvalid", DValid, 1);
      tick();

      // MC_EN=0 instance: MUL decodes as NOP
      Instr = 32'hE0000291; InstrValid = 1;
      tick();
      InstrValid = 0;
      chk("nomc_dvalid", n_DValid, 1);
      chk("nomc_regw", n_RegW, 0);
      chk("nomc_bundle", nomc_bundle(), 0);
      chk("nomc_mstart", n_M_Start, 0);
      chk("mc_mstart_cmp", M_Start, 1);
      tick();
      chk("nomc_mstart_later", n_M_Start, 0);
      Flush = 1;
      tick();
      Flush = 0;
      chk("nomc_flush_dvalid", DValid, 0);

      // DIV with no MC_Done: watchdog expires after 8 cycles
      Instr = 32'hE7F102F3; InstrValid = 1;
      tick();
      InstrValid = 0;
      chk("div_mstart", M_Start, 1);
      chk("div_op", MCycleOp, 1);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k < 8) begin
            chk("to_early", McTimeout, 0);
            chk("to_wait_ready", InstrReady, 0);
         end else begin
            chk("to_flag", McTimeout, 1);
            chk("to_dvalid", DValid, 0);
            chk("to_idle_ready", InstrReady, 1);
         end
      end
      Instr = 32'hE0821003; InstrValid = 1;
      tick();
      InstrValid = 0;
      chk("to_sticky_dvalid", DValid, 1);
      chk("to_sticky", McTimeout, 1);
      chk("nomc_no_timeout", n_McTimeout, 0);

      // Randomized non-MC traffic with flush and backpressure
      exp_v = 1'b1;
      exp_b = ref_decode(32'hE0821003);
      for (int c = 0; c < 300; c++) begin
         iv = ($urandom_range(0, 9) < 7);
         er = ($urandom_range(0, 9) < 7);
         fl = ($urandom_range(0, 19) == 0);
         Instr = rand_instr(); InstrValid = iv; ExReady = er; Flush = fl;
         #1;
         exp_rdy = !fl && (!exp_v || er);
         chk("rnd_ready", InstrReady, exp_rdy);
         if (fl) exp_v = 1'b0;
         else if (iv && exp_rdy) begin exp_v = 1'b1; exp_b = ref_decode(Instr); end
         else if (er) exp_v = 1'b0;
         tick();
         chk("rnd_dvalid", DValid, exp_v);
         if (exp_v) chk("rnd_bundle", dut_bundle(), exp_b);
         chk("rnd_mstart", M_Start, 0);
      end
      InstrValid = 0; Flush = 0;
      chk("rnd_timeout_sticky", McTimeout, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
